if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, word address fetched first after reset.
REQ-002 Parameter QDEPTH, 4, prefetch queue depth in 32-bit words (power of two, min 2).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  word-aligned fetch address; bits [1:0] always 0.
REQ-007 imem_ack  input  1  imem_rdata valid this cycle for the oldest outstanding request.
REQ-008 imem_rdata  input  32  fetched word; halfword at lower address in [31:16].
REQ-009 branch_taken  input  1  redirect strobe from execute.
REQ-010 branch_target  input  32  redirect address; bit 0 ignored, bit 1 may be set.
REQ-011 stall  input  1  splitter busy; driven by multiple OR (list != 0).
REQ-012 instruction  output  32  word delivered to the 16/32-bit splitter.
REQ-013 pc  output  32  word address of instruction.
REQ-014 inst_valid  output  1  instruction/pc carry a real fetched word.
REQ-015 odd_start  output  1  first word after a redirect to a target with bit 1 set; upper halfword is dead.

Function
REQ-016 At most one request outstanding; imem_req SHALL assert only when (count + outstanding) < QDEPTH and no redirect occurs this cycle.
REQ-017 imem_addr increments by 4 per issued request; wrap 32'hFFFF_FFFC -> 0 is silent.
REQ-018 Data on imem_ack (not discarded) SHALL be pushed into the queue with its address the same edge.
REQ-019 When stall=0 and queue non-empty, the head SHALL pop into instruction/pc with inst_valid=1 on the next edge; latency from ack to inst_valid is 1 cycle when the queue is empty.
REQ-020 When stall=0 and queue empty, next edge: inst_valid=0, instruction=32'hBF00_BF00 (NOP pair), pc unchanged.
REQ-021 When stall=1, instruction, pc, inst_valid and odd_start SHALL hold; the queue continues to fill up to QDEPTH.
REQ-022 Simultaneous push and pop: both occur, count unchanged; the queue cannot overflow by REQ-016.
REQ-023 branch_taken=1 SHALL take priority over push, pop and stall: the queue is flushed, any outstanding response is marked discard, and the fetch address becomes {branch_target[31:2],2'b00}; inst_valid=0 and instruction=NOP pair on the next edge.
REQ-024 A discarded response SHALL be consumed at its imem_ack without a push; a new request SHALL NOT issue until that ack arrives.
REQ-025 odd_start SHALL be 1 only together with the first valid word popped after a redirect with branch_target[1]=1, and 0 otherwise.
REQ-026 A second branch_taken while a discard is pending SHALL retarget again with no extra discard.

Reset
REQ-027 On rst: imem_req=0, imem_addr=RESET_PC, queue empty, outstanding=0, discard=0, inst_valid=0, instruction=32'hBF00_BF00, pc=0, odd_start=0.
REQ-028 rst SHALL override every other input in the same cycle; a response in flight at reset SHALL be discarded.
REQ-029 The first request SHALL issue in the first cycle after rst deasserts.

Structure
REQ-030 Shared package cm0_pkg holds NOP16 (16'hBF00), NOP_PAIR, the default RESET_PC and the address width.
REQ-031 The queue SHALL be a sub-module fetch_fifo (parameterised depth, 64-bit entries {addr,data}, push/pop/flush, count, full/empty).

Verification
REQ-032 Reset, memory acks every cycle -> imem_addr sequence 0,4,8,C; instruction sequence 0x0,0x4,0x8 words with inst_valid from cycle 2 after the first ack.
REQ-033 stall=1 for 10 cycles -> outputs frozen, exactly QDEPTH=4 requests issued, then imem_req=0; release -> 4 consecutive pops, no gap.
REQ-034 branch_taken with target 0x0000_0102 while one request is outstanding -> the stale ack is dropped, the next imem_addr is 0x100, the first valid word has pc=0x100 and odd_start=1.
REQ-035 branch_taken coincident with stall=1 and a full queue -> next edge inst_valid=0, instruction=0xBF00_BF00, queue count=0.
REQ-036 imem_ack delayed 3 cycles per request -> NOP pairs with inst_valid=0 between words, pc strictly +4.
REQ-037 rst pulse mid-stream with an ack in the same cycle -> RESET_PC refetched, no pre-reset word ever appears with inst_valid=1.

Source files
------------

// File: rtl/cm0_pkg.sv
// Shared constants and types for the Cortex-M0-style fetch front end.
package cm0_pkg;

  localparam int                ADDR_W           = 32;
  localparam logic [15:0]       NOP16            = 16'hBF00;
  localparam logic [31:0]       NOP_PAIR         = {NOP16, NOP16};
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = '0;

  // One prefetch queue entry: word address and the word fetched from it.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } fetch_entry_t;

  // Life cycle of the single outstanding memory request.
  typedef enum logic [1:0] {
    RSP_IDLE,
    RSP_WAIT,
    RSP_DISCARD
  } rsp_state_t;

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
interface if_fetch_if;

  logic                        imem_req;
  logic [cm0_pkg::ADDR_W-1:0]  imem_addr;
  logic                        imem_ack;
  logic [31:0]                 imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue of {addr,data} entries with push, pop and single-cycle flush.
module fetch_fifo
  import cm0_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int               PTR_W     = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !flush && !full;
    do_pop   = pop && !flush && !empty;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
      else if (do_pop && !do_push) count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; an entry is only read after it has been written (count guards it).
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: one outstanding memory request, prefetch queue, redirect with discard.
module if_fetch
  import cm0_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int                QDEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  if_fetch_if.master        imem,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              stall,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] pc,
  output logic              inst_valid,
  output logic              odd_start
);

  localparam int                CNT_W     = $clog2(QDEPTH) + 1;
  localparam logic [CNT_W:0]    DEPTH_LIM = (CNT_W + 1)'(QDEPTH);
  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

  rsp_state_t        rsp_state_q, rsp_state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              odd_pending_q, odd_pending_d;
  logic [31:0]       instruction_q, instruction_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inst_valid_q, inst_valid_d;
  logic              odd_start_q, odd_start_d;

  logic              issue, push, pop, ack_done, slot_free;
  logic [CNT_W:0]    inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;
  fetch_entry_t      fifo_head, push_entry;
  logic              unused_target_bit;

  // Bit 0 of the redirect target never names a halfword boundary we care about.
  assign unused_target_bit = branch_target[0];

  fetch_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (branch_taken),
    .head       (fifo_head),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign push_entry     = '{addr: req_addr_q, data: imem.imem_rdata};
  assign imem.imem_req  = issue;
  assign imem.imem_addr = fetch_addr_q;
  assign instruction    = instruction_q;
  assign pc             = pc_q;
  assign inst_valid     = inst_valid_q;
  assign odd_start      = odd_start_q;

  always_comb begin
    rsp_state_d   = rsp_state_q;
    fetch_addr_d  = fetch_addr_q;
    req_addr_d    = req_addr_q;
    odd_pending_d = odd_pending_q;
    instruction_d = instruction_q;
    pc_d          = pc_q;
    inst_valid_d  = inst_valid_q;
    odd_start_d   = odd_start_q;
    issue         = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;

    // The ack that retires a request frees the slot for a new request in the same cycle.
    ack_done  = imem.imem_ack && (rsp_state_q != RSP_IDLE);
    slot_free = (rsp_state_q == RSP_IDLE) || ack_done;
    inflight  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rsp_state_q != RSP_IDLE};

    if (branch_taken) begin
      fetch_addr_d  = {branch_target[ADDR_W-1:2], 2'b00};
      odd_pending_d = branch_target[1];
      rsp_state_d   = (rsp_state_q != RSP_IDLE && !imem.imem_ack) ? RSP_DISCARD : RSP_IDLE;
      instruction_d = NOP_PAIR;
      inst_valid_d  = 1'b0;
      odd_start_d   = 1'b0;
    end else begin
      push  = ack_done && (rsp_state_q == RSP_WAIT) && !rst;
      issue = slot_free && (inflight < DEPTH_LIM) && !fifo_full && !rst;
      if (issue) begin
        req_addr_d   = fetch_addr_q;
        fetch_addr_d = fetch_addr_q + WORD_STEP;
        rsp_state_d  = RSP_WAIT;
      end else if (ack_done) begin
        rsp_state_d  = RSP_IDLE;
      end

      if (!stall) begin
        if (!fifo_empty) begin
          pop           = 1'b1;
          instruction_d = fifo_head.data;
          pc_d          = fifo_head.addr;
          inst_valid_d  = 1'b1;
          odd_start_d   = odd_pending_q;
          odd_pending_d = 1'b0;
        end else begin
          instruction_d = NOP_PAIR;
          inst_valid_d  = 1'b0;
          odd_start_d   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_state_q   <= RSP_IDLE;
      fetch_addr_q  <= RESET_PC;
      req_addr_q    <= '0;
      odd_pending_q <= 1'b0;
      instruction_q <= NOP_PAIR;
      pc_q          <= '0;
      inst_valid_q  <= 1'b0;
      odd_start_q   <= 1'b0;
    end else begin
      rsp_state_q   <= rsp_state_d;
      fetch_addr_q  <= fetch_addr_d;
      req_addr_q    <= req_addr_d;
      odd_pending_q <= odd_pending_d;
      instruction_q <= instruction_d;
      pc_q          <= pc_d;
      inst_valid_q  <= inst_valid_d;
      odd_start_q   <= odd_start_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: memory responder plus a queue-based reference model.
module tb_if_fetch;
  import cm0_pkg::*;

  localparam int          QDEPTH   = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, branch_taken, stall;
  logic [31:0] branch_target, instruction, pc;
  logic        inst_valid, odd_start;

  if_fetch_if bus ();

  if_fetch #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (bus),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .instruction   (instruction),
    .pc            (pc),
    .inst_valid    (inst_valid),
    .odd_start     (odd_start)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Memory responder: one pending request, acked after mem_wait further cycles.
  bit          mem_pend;
  logic [31:0] mem_addr;
  int          mem_wait;
  int          mem_delay;
  bit          mem_rand;

  // Reference model state.
  logic [63:0] m_q[$];
  bit          m_out, m_disc, m_oddp, m_valid, m_odd;
  logic [31:0] m_next, m_req_addr, m_instr, m_pc;

  bit          last_req;
  logic [31:0] last_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'hC3A5_5A3C;
  endfunction

  function void model_reset();
    m_q.delete();
    m_out = 0; m_disc = 0; m_oddp = 0; m_valid = 0; m_odd = 0;
    m_next = RESET_PC; m_req_addr = '0; m_instr = NOP_PAIR; m_pc = '0;
  endfunction

  function automatic bit model_req(input bit r, input bit br, input bit ack);
    return !r && !br && (!m_out || ack) && ((m_q.size() + int'(m_out)) < QDEPTH);
  endfunction

  task automatic model_update(input bit r, input bit br, input logic [31:0] tgt,
                              input bit st, input bit ack, input logic [31:0] rd, input bit req);
    logic [63:0] head;
    bit          have;
    head = '0;
    if (r) begin
      model_reset();
    end else if (br) begin
      m_q.delete();
      m_disc  = m_out && !ack;
      m_out   = m_out && !ack;
      m_next  = {tgt[31:2], 2'b00};
      m_oddp  = tgt[1];
      m_valid = 0; m_instr = NOP_PAIR; m_odd = 0;
    end else begin
      have = !st && (m_q.size() > 0);
      if (have) head = m_q.pop_front();
      if (ack && m_out && !m_disc) m_q.push_back({m_req_addr, rd});
      if (ack) begin m_out = 0; m_disc = 0; end
      if (req) begin m_out = 1; m_req_addr = m_next; m_next = m_next + 32'd4; end
      if (!st) begin
        if (have) begin
          m_valid = 1; m_instr = head[31:0]; m_pc = head[63:32]; m_odd = m_oddp; m_oddp = 0;
        end else begin
          m_valid = 0; m_instr = NOP_PAIR; m_odd = 0;
        end
      end
    end
  endtask

  // One clock cycle: drive inputs, check the request, advance model and memory, check outputs.
  task automatic step(input bit r, input bit br, input logic [31:0] tgt, input bit st);
    bit          ack, exp_req;
    logic [31:0] rd;
    ack = mem_pend && (mem_wait == 0);
    rd  = ack ? mem_word(mem_addr) : $urandom();
    rst = r; branch_taken = br; stall = st;
    branch_target = br ? tgt : $urandom();
    bus.imem_ack = ack; bus.imem_rdata = rd;
    #3;
    exp_req = model_req(r, br, ack);
    total++;
    if (bus.imem_req !== exp_req) begin
      bad++; $display("FAIL imem_req cyc=%0d got=%b exp=%b", cyc, bus.imem_req, exp_req);
    end
    if (exp_req) begin
      total++;
      if (bus.imem_addr !== m_next) begin
        bad++; $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, bus.imem_addr, m_next);
      end
    end
    total++;
    if (bus.imem_addr[1:0] !== 2'b00) begin
      bad++; $display("FAIL addr_align cyc=%0d got=%b exp=00", cyc, bus.imem_addr[1:0]);
    end
    last_req  = (bus.imem_req === 1'b1);
    last_addr = bus.imem_addr;
    model_update(r, br, tgt, st, ack, rd, exp_req);
    if (ack || r) mem_pend = 0;
    else if (mem_pend) mem_wait--;
    if (last_req) begin
      mem_pend = 1; mem_addr = last_addr;
      mem_wait = mem_rand ? int'($urandom_range(0, 3)) : mem_delay;
    end
    @(posedge clk);
    #1;
    total++;
    if (inst_valid !== m_valid) begin
      bad++; $display("FAIL inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid, m_valid);
    end
    total++;
    if (instruction !== m_instr) begin
      bad++; $display("FAIL instruction cyc=%0d got=%h exp=%h", cyc, instruction, m_instr);
    end
    total++;
    if (pc !== m_pc) begin
      bad++; $display("FAIL pc cyc=%0d got=%h exp=%h", cyc, pc, m_pc);
    end
    total++;
    if (odd_start !== m_odd) begin
      bad++; $display("FAIL odd_start cyc=%0d got=%b exp=%b", cyc, odd_start, m_odd);
    end
    cyc++;
  endtask

  task automatic do_reset();
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);
  endtask

  // Advance until a request is pending whose ack is at least min_wait cycles away.
  task automatic wait_pending(input int min_wait);
    int n;
    n = 0;
    while (!(mem_pend && mem_wait >= min_wait) && n < 20) begin
      step(0, 0, '0, 0);
      n++;
    end
    total++;
    if (n >= 20) begin
      bad++; $display("FAIL wait_pending_timeout got=%0d exp<20", n);
    end
  endtask

  task automatic test_reset();
    mem_delay = 0; mem_rand = 0;
    do_reset();
    total++;
    if (inst_valid !== 1'b0 || instruction !== NOP_PAIR || pc !== 32'h0 || odd_start !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b/%h/%h/%b exp=0/%h/0/0", inst_valid, instruction, pc, odd_start, NOP_PAIR);
    end
    #2;
    total++;
    if (bus.imem_req !== 1'b0 || bus.imem_addr !== RESET_PC) begin
      bad++; $display("FAIL reset_bus got=%b/%h exp=0/%h", bus.imem_req, bus.imem_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    logic [31:0] reqs[$];
    logic [31:0] pcs[$];
    int          first_valid;
    first_valid = -1;
    mem_delay = 0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(0, 0, '0, 0);
      if (i == 0) begin
        total++;
        if (!last_req) begin bad++; $display("FAIL first_req_after_rst got=0 exp=1"); end
      end
      if (last_req) reqs.push_back(last_addr);
      if (inst_valid === 1'b1) begin
        if (first_valid < 0) first_valid = i;
        pcs.push_back(pc);
      end
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (reqs.size() <= k || reqs[k] !== RESET_PC + 32'(4 * k)) begin
        bad++; $display("FAIL stream_addr%0d got=%h exp=%h", k, (reqs.size() > k) ? reqs[k] : 32'hx, RESET_PC + 32'(4 * k));
      end
    end
    total++;
    if (first_valid != 2) begin bad++; $display("FAIL first_valid_cycle got=%0d exp=2", first_valid); end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (pcs.size() <= k || pcs[k] !== RESET_PC + 32'(4 * k)) begin
        bad++; $display("FAIL stream_pc%0d got=%h exp=%h", k, (pcs.size() > k) ? pcs[k] : 32'hx, RESET_PC + 32'(4 * k));
      end
    end
  endtask

  task automatic test_stall();
    int nreq;
    nreq = 0;
    mem_delay = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(0, 0, '0, 1);
      nreq += int'(last_req);
    end
    total++;
    if (nreq != QDEPTH) begin bad++; $display("FAIL stall_req_count got=%0d exp=%0d", nreq, QDEPTH); end
    total++;
    if (last_req) begin bad++; $display("FAIL stall_req_idle got=1 exp=0"); end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, '0, 0);
      total++;
      if (inst_valid !== 1'b1 || pc !== RESET_PC + 32'(4 * i)) begin
        bad++; $display("FAIL release_pop%0d got=%b/%h exp=1/%h", i, inst_valid, pc, RESET_PC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_branch();
    logic [31:0] first_addr, first_pc;
    bit          got_addr, got_pc, first_odd, second_odd, got_second;
    got_addr = 0; got_pc = 0; got_second = 0;
    first_addr = '0; first_pc = '0; first_odd = 0; second_odd = 0;
    mem_delay = 2;
    do_reset();
    repeat (6) step(0, 0, '0, 0);
    wait_pending(1);
    step(0, 1, 32'h0000_0102, 0);
    total++;
    if (inst_valid !== 1'b0 || instruction !== NOP_PAIR) begin
      bad++; $display("FAIL branch_flush got=%b/%h exp=0/%h", inst_valid, instruction, NOP_PAIR);
    end
    for (int i = 0; i < 30; i++) begin
      step(0, 0, '0, 0);
      if (last_req && !got_addr) begin got_addr = 1; first_addr = last_addr; end
      if (inst_valid === 1'b1) begin
        if (got_pc && !got_second) begin got_second = 1; second_odd = odd_start; end
        if (!got_pc) begin got_pc = 1; first_pc = pc; first_odd = odd_start; end
      end
    end
    total++;
    if (!got_addr || first_addr !== 32'h100) begin bad++; $display("FAIL branch_addr got=%h exp=00000100", first_addr); end
    total++;
    if (!got_pc || first_pc !== 32'h100 || !first_odd) begin
      bad++; $display("FAIL branch_first_word got=%h/%b exp=00000100/1", first_pc, first_odd);
    end
    total++;
    if (!got_second || second_odd) begin bad++; $display("FAIL branch_second_odd got=%b exp=0", second_odd); end
  endtask

  task automatic test_branch_stall_full();
    logic [31:0] first_pc;
    bit          got_pc, first_odd;
    got_pc = 0; first_pc = '0; first_odd = 0;
    mem_delay = 0;
    do_reset();
    repeat (8) step(0, 0, '0, 1);
    total++;
    if (dut.u_fifo.count !== 3'(QDEPTH)) begin bad++; $display("FAIL queue_full got=%0d exp=%0d", dut.u_fifo.count, QDEPTH); end
    step(0, 1, 32'h0000_0040, 1);
    total++;
    if (inst_valid !== 1'b0 || instruction !== NOP_PAIR || dut.u_fifo.count !== '0) begin
      bad++;
      $display("FAIL branch_stall got=%b/%h/%0d exp=0/%h/0", inst_valid, instruction, dut.u_fifo.count, NOP_PAIR);
    end
    for (int i = 0; i < 15; i++) begin
      step(0, 0, '0, 0);
      if (inst_valid === 1'b1 && !got_pc) begin got_pc = 1; first_pc = pc; first_odd = odd_start; end
    end
    total++;
    if (!got_pc || first_pc !== 32'h40 || first_odd) begin
      bad++; $display("FAIL branch_stall_resume got=%h/%b exp=00000040/0", first_pc, first_odd);
    end
  endtask

  task automatic test_slow_mem();
    int          nvalid;
    bit          prev_valid;
    logic [31:0] prev_pc;
    nvalid = 0; prev_valid = 0; prev_pc = '0;
    mem_delay = 3;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      step(0, 0, '0, 0);
      if (inst_valid === 1'b1) begin
        if (nvalid > 0) begin
          total++;
          if (pc !== prev_pc + 32'd4) begin bad++; $display("FAIL slow_pc_step got=%h exp=%h", pc, prev_pc + 32'd4); end
          total++;
          if (prev_valid) begin bad++; $display("FAIL slow_gap got=1 exp=0"); end
        end
        nvalid++;
        prev_pc = pc;
      end
      prev_valid = (inst_valid === 1'b1);
    end
    total++;
    if (nvalid < 10) begin bad++; $display("FAIL slow_word_count got=%0d exp>=10", nvalid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] first_addr, first_pc;
    bit          got_addr, got_pc, first_odd;
    got_addr = 0; got_pc = 0; first_addr = '0; first_pc = '0; first_odd = 0;
    mem_delay = 3;
    do_reset();
    repeat (3) step(0, 0, '0, 0);
    wait_pending(2);
    step(0, 1, 32'h0000_0200, 0);
    step(0, 1, 32'h0000_0302, 0);
    for (int i = 0; i < 30; i++) begin
      step(0, 0, '0, 0);
      if (last_req && !got_addr) begin got_addr = 1; first_addr = last_addr; end
      if (inst_valid === 1'b1 && !got_pc) begin got_pc = 1; first_pc = pc; first_odd = odd_start; end
    end
    total++;
    if (!got_addr || first_addr !== 32'h300) begin bad++; $display("FAIL retarget_addr got=%h exp=00000300", first_addr); end
    total++;
    if (!got_pc || first_pc !== 32'h300 || !first_odd) begin
      bad++; $display("FAIL retarget_word got=%h/%b exp=00000300/1", first_pc, first_odd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] first_pc;
    bit          got_pc;
    got_pc = 0; first_pc = '0;
    mem_delay = 0;
    do_reset();
    repeat (6) step(0, 0, '0, 0);
    wait_pending(0);
    total++;
    if (!(mem_pend && mem_wait == 0)) begin bad++; $display("FAIL reset_mid_ack got=0 exp=1"); end
    step(1, 0, '0, 0);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, '0, 0);
      if (i == 0) begin
        total++;
        if (!last_req || last_addr !== RESET_PC) begin
          bad++; $display("FAIL refetch got=%b/%h exp=1/%h", last_req, last_addr, RESET_PC);
        end
      end
      if (inst_valid === 1'b1 && !got_pc) begin got_pc = 1; first_pc = pc; end
    end
    total++;
    if (!got_pc || first_pc !== RESET_PC) begin bad++; $display("FAIL reset_mid_first got=%h exp=%h", first_pc, RESET_PC); end
  endtask

  task automatic test_random();
    bit          r, br, st;
    logic [31:0] tgt;
    mem_rand = 1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      br  = ($urandom_range(0, 19) == 0);
      st  = ($urandom_range(0, 3) == 0);
      tgt = $urandom();
      step(r, br, tgt, st);
    end
    mem_rand = 0;
  endtask

  initial begin
    rst = 1; branch_taken = 0; stall = 0; branch_target = '0;
    bus.imem_ack = 0; bus.imem_rdata = '0;
    mem_pend = 0; mem_addr = '0; mem_wait = 0; mem_delay = 0; mem_rand = 0;
    last_req = 0; last_addr = '0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_branch_stall_full();
    test_slow_mem();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
